param_universal_reg: RTL and testbench



---
 rtl/param_universal_reg.sv | 86 ++++++++
 tb/tb_param_universal_reg.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/param_universal_reg.sv
// WIDTH-bit universal register: hold, load, shift, rotate, up/down count, with async and sync clear.
// One-cycle latency for every mode; no backpressure (en=0 simply holds state).
module param_universal_reg #(
  parameter int               WIDTH       = 8,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             sclr,
  input  logic             en,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] D,
  input  logic             ser_in,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] not_Q,
  output logic             ser_out,
  output logic             tc
);

  localparam logic [2:0] MODE_HOLD = 3'b000;
  localparam logic [2:0] MODE_LOAD = 3'b001;
  localparam logic [2:0] MODE_SHL  = 3'b010;
  localparam logic [2:0] MODE_SHR  = 3'b011;
  localparam logic [2:0] MODE_ROL  = 3'b100;
  localparam logic [2:0] MODE_ROR  = 3'b101;
  localparam logic [2:0] MODE_UP   = 3'b110;
  localparam logic [2:0] MODE_DOWN = 3'b111;

  localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] ONES = '1;
  localparam logic [WIDTH-1:0] ZERO = '0;

  logic [WIDTH-1:0] q_r;
  logic             so_r;
  logic [WIDTH-1:0] q_nxt;
  logic             so_nxt;

  always_comb begin
    q_nxt  = q_r;
    so_nxt = so_r;
    unique case (mode)
      MODE_HOLD: q_nxt = q_r;
      MODE_LOAD: q_nxt = D;
      MODE_SHL: begin
        q_nxt  = {q_r[WIDTH-2:0], ser_in};
        so_nxt = q_r[WIDTH-1];
      end
      MODE_SHR: begin
        q_nxt  = {ser_in, q_r[WIDTH-1:1]};
        so_nxt = q_r[0];
      end
      MODE_ROL: begin
        q_nxt  = {q_r[WIDTH-2:0], q_r[WIDTH-1]};
        so_nxt = q_r[WIDTH-1];
      end
      MODE_ROR: begin
        q_nxt  = {q_r[0], q_r[WIDTH-1:1]};
        so_nxt = q_r[0];
      end
      MODE_UP:   q_nxt = q_r + ONE;
      MODE_DOWN: q_nxt = q_r - ONE;
      default:   q_nxt = q_r;
    endcase
  end

  // sclr outranks en so a disabled register can still be cleared
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      q_r  <= RESET_VALUE;
      so_r <= 1'b0;
    end else if (sclr) begin
      q_r  <= RESET_VALUE;
      so_r <= 1'b0;
    end else if (en) begin
      q_r  <= q_nxt;
      so_r <= so_nxt;
    end
  end

  assign Q       = q_r;
  assign not_Q   = ~q_r;
  assign ser_out = so_r;
  assign tc      = en & (((mode == MODE_UP) & (q_r == ONES)) |
                         ((mode == MODE_DOWN) & (q_r == ZERO)));

endmodule

// File: tb/tb_param_universal_reg.sv
// Randomized scoreboard bench for param_universal_reg, driving an 8-bit and a 4-bit instance in lockstep.
module tb_param_universal_reg;

  logic       clk = 1'b0;
  logic       clr, sclr, en, si;
  logic [2:0] mode;
  logic [7:0] d8;
  logic [3:0] d4;
  logic [7:0] q8, nq8;
  logic [3:0] q4, nq4;
  logic       so8, tc8, so4, tc4;

  param_universal_reg #(.WIDTH(8), .RESET_VALUE(8'h00)) dut8 (
    .clk(clk), .clr(clr), .sclr(sclr), .en(en), .mode(mode), .D(d8), .ser_in(si),
    .Q(q8), .not_Q(nq8), .ser_out(so8), .tc(tc8)
  );

  param_universal_reg #(.WIDTH(4), .RESET_VALUE(4'hA)) dut4 (
    .clk(clk), .clr(clr), .sclr(sclr), .en(en), .mode(mode), .D(d4), .ser_in(si),
    .Q(q4), .not_Q(nq4), .ser_out(so4), .tc(tc4)
  );

  always #5 clk = ~clk;

  typedef struct {
    int q8, so8, q4, so4;
    bit tc8, tc4;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;
  int   mq8, mso8, mq4, mso4;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: arithmetic on integers, one call per clock edge.
  function automatic void model(input int w, input int rv, input int q, input int so,
                                input bit sc, input bit e, input int md, input int d,
                                input int s, output int nq, output int nso, output bit t);
    int m   = 1 << w;
    int top = m / 2;
    nq  = q;
    nso = so;
    t   = e && ((md == 6 && q == m - 1) || (md == 7 && q == 0));
    if (sc) begin
      nq  = rv;
      nso = 0;
    end else if (e) begin
      case (md)
        1: nq = d % m;
        2: begin nso = q / top; nq = (q * 2) % m + s;       end
        3: begin nso = q % 2;   nq = q / 2 + s * top;       end
        4: begin nso = q / top; nq = (q * 2) % m + q / top; end
        5: begin nso = q % 2;   nq = q / 2 + (q % 2) * top; end
        6: nq = (q + 1) % m;
        7: nq = (q + m - 1) % m;
        default: ;
      endcase
    end
  endfunction

  task automatic step(input bit sc, input bit e, input int md, input int d, input bit s);
    exp_t x;
    @(negedge clk);
    sclr = sc; en = e; mode = 3'(md); d8 = 8'(d); d4 = 4'(d); si = s;
    model(8, 8'h00, mq8, mso8, sc, e, md, d & 8'hFF, s, x.q8, x.so8, x.tc8);
    model(4, 4'hA,  mq4, mso4, sc, e, md, d & 4'hF,  s, x.q4, x.so4, x.tc4);
    mq8 = x.q8; mso8 = x.so8; mq4 = x.q4; mso4 = x.so4;
    sb.push_back(x);
  endtask

  task automatic expect_now(input string name, input logic [7:0] e8, input logic [3:0] e4);
    @(posedge clk);
    #2;
    chk({name, "_q8"}, 32'(q8), 32'(e8));
    chk({name, "_q4"}, 32'(q4), 32'(e4));
  endtask

  task automatic do_clr();
    @(negedge clk);
    #3;
    clr = 1'b1;
    #1;
    chk("clr_q8", 32'(q8), 32'h00);
    chk("clr_nq8", 32'(nq8), 32'hFF);
    chk("clr_so8", 32'(so8), 32'h0);
    chk("clr_q4", 32'(q4), 32'hA);
    chk("clr_nq4", 32'(nq4), 32'h5);
    chk("clr_so4", 32'(so4), 32'h0);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      sclr = 1'b0; en = 1'b1; mode = 3'b001; d8 = 8'($urandom); d4 = 4'($urandom);
      @(posedge clk);
      #2;
      chk("clr_hold_q8", 32'(q8), 32'h00);
      chk("clr_hold_q4", 32'(q4), 32'hA);
    end
    @(negedge clk);
    en = 1'b0; sclr = 1'b0;
    clr = 1'b0;
    mq8 = 0; mso8 = 0; mq4 = 4'hA; mso4 = 0;
  endtask

  // Monitor: tc checked mid-cycle against the pending entry, Q/ser_out after the edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (sb.size() > 0) begin
        chk("tc8", 32'(tc8), 32'(sb[0].tc8));
        chk("tc4", 32'(tc4), 32'(sb[0].tc4));
      end
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("q8", 32'(q8), 32'(e.q8));
        chk("nq8", 32'(nq8), 32'(~e.q8 & 8'hFF));
        chk("so8", 32'(so8), 32'(e.so8));
        chk("q4", 32'(q4), 32'(e.q4));
        chk("nq4", 32'(nq4), 32'(~e.q4 & 4'hF));
        chk("so4", 32'(so4), 32'(e.so4));
      end
    end
  end

  initial begin
    clr = 1'b1; sclr = 1'b0; en = 1'b0; mode = 3'b000; d8 = '0; d4 = '0; si = 1'b0;
    #3;
    chk("rst_q8", 32'(q8), 32'h00);
    chk("rst_nq8", 32'(nq8), 32'hFF);
    chk("rst_so8", 32'(so8), 32'h0);
    chk("rst_q4", 32'(q4), 32'hA);
    chk("rst_nq4", 32'(nq4), 32'h5);
    @(negedge clk);
    clr = 1'b0;
    mq8 = 0; mso8 = 0; mq4 = 4'hA; mso4 = 0;

    // Async clear partway through operation
    step(0, 1, 1, 8'hA5, 0);
    expect_now("load_a5", 8'hA5, 4'h5);
    do_clr();

    // Load, enable-hold, sclr while disabled
    step(0, 1, 1, 8'h3C, 0);
    expect_now("load_3c", 8'h3C, 4'hC);
    for (int i = 0; i < 3; i++) step(0, 0, 1, 8'hFF, 0);
    expect_now("en_hold", 8'h3C, 4'hC);
    step(1, 0, 1, 8'hFF, 0);
    expect_now("sclr_dis", 8'h00, 4'hA);

    // Shift left then right with serial out
    step(0, 1, 1, 8'h81, 0);
    step(0, 1, 2, 0, 0);
    expect_now("shl", 8'h02, 4'h2);
    chk("shl_so8", 32'(so8), 32'h1);
    step(0, 1, 3, 0, 1);
    expect_now("shr", 8'h81, 4'h9);
    chk("shr_so8", 32'(so8), 32'h0);

    // Rotate right full circle
    step(0, 1, 1, 8'h01, 0);
    step(0, 1, 5, 0, 0);
    expect_now("ror1", 8'h80, 4'h8);
    for (int i = 0; i < 7; i++) step(0, 1, 5, 0, 0);
    expect_now("ror8", 8'h01, 4'h1);

    // Count up through wrap, then count down from zero
    step(0, 1, 1, 8'hFE, 0);
    step(0, 1, 6, 0, 0);
    expect_now("up_ff", 8'hFF, 4'hF);
    step(0, 1, 6, 0, 0);
    expect_now("up_wrap", 8'h00, 4'h0);
    step(0, 1, 7, 0, 0);
    expect_now("dn_wrap", 8'hFF, 4'hF);
    step(1, 1, 6, 0, 0);
    expect_now("sclr_rv", 8'h00, 4'hA);

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 39) == 0)
        do_clr();
      else
        step($urandom_range(0, 9) == 0, $urandom_range(0, 3) != 0,
             int'($urandom_range(0, 7)), int'($urandom_range(0, 255)),
             1'($urandom_range(0, 1)));
    end

    step(0, 0, 0, 0, 0);
    repeat (3) @(posedge clk);
    #2;
    chk("sb_drained", 32'(sb.size()), 32'h0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
